// File: rtl/crank_wheel_gen_if.sv
// Configuration and waveform signals of the crank trigger-wheel generator.
// Config inputs are level-sampled, not handshaked; tick_cnt exposes the in-tooth tick position.
interface crank_wheel_gen_if #(
    parameter int TOOTH_W = 16,
    parameter int TEETH_W = 8,
    parameter int PRE_W   = 8
);
    logic               en;
    logic [PRE_W-1:0]   prescale;
    logic [TOOTH_W-1:0] tooth_top;
    logic [1:0]         gap_mult;
    logic [TEETH_W-1:0] teeth_last;
    logic               vr_out;
    logic [TEETH_W-1:0] tooth_idx;
    logic               tooth_stb;
    logic               rev_stb;
    logic [TOOTH_W+1:0] tick_cnt;

    modport master (
        output en, prescale, tooth_top, gap_mult, teeth_last,
        input  vr_out, tooth_idx, tooth_stb, rev_stb, tick_cnt
    );

    modport slave (
        input  en, prescale, tooth_top, gap_mult, teeth_last,
        output vr_out, tooth_idx, tooth_stb, rev_stb, tick_cnt
    );
endinterface

// File: rtl/crank_wheel_gen.sv
// 60-2 style crank trigger-wheel generator: N normal teeth followed by one elongated
// gap tooth, paced by a clock prescaler. Tooth geometry is shadowed per revolution.
module crank_wheel_gen #(
    parameter int TOOTH_W = 16,
    parameter int TEETH_W = 8,
    parameter int PRE_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    crank_wheel_gen_if.slave bus
);
    localparam int CW = TOOTH_W + 2;

    logic [PRE_W-1:0]   pcnt;
    logic [CW-1:0]      tckc;
    logic               vr_q;
    logic [TEETH_W-1:0] idx_q;
    logic               stb_q;
    logic               rev_q;
    logic [TOOTH_W-1:0] top_s;
    logic [1:0]         gmul_s;
    logic [TEETH_W-1:0] last_s;
    logic               loaded;

    logic [TOOTH_W-1:0] top_e;
    logic [1:0]         gmul_e;
    logic [TEETH_W-1:0] last_e;
    logic [CW-1:0]      gmul_w;
    logic [CW-1:0]      top_w;
    logic [CW-1:0]      cur_top;
    logic [CW-1:0]      half;
    logic               tick;
    logic               at_end;
    logic               at_half;
    logic               at_last;

    // Until the first load after reset the shadow is empty, so the live inputs stand in for it.
    always_comb begin
        top_e   = loaded ? top_s  : bus.tooth_top;
        gmul_e  = loaded ? gmul_s : bus.gap_mult;
        last_e  = loaded ? last_s : bus.teeth_last;
        gmul_w  = (gmul_e == 2'd0) ? CW'(1) : CW'(gmul_e);
        top_w   = CW'(top_e);
        cur_top = (idx_q == '0) ? (gmul_w * (top_w + CW'(1))) - CW'(1) : top_w;
        half    = cur_top >> 1;
        tick    = (pcnt == bus.prescale);
        at_end  = (tckc == cur_top);
        at_half = (tckc == half);
        at_last = (idx_q == last_e);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt   <= '0;
            tckc   <= '0;
            vr_q   <= 1'b0;
            idx_q  <= TEETH_W'(1);
            stb_q  <= 1'b0;
            rev_q  <= 1'b0;
            top_s  <= '0;
            gmul_s <= '0;
            last_s <= '0;
            loaded <= 1'b0;
        end else if (!bus.en) begin
            pcnt   <= '0;
            tckc   <= '0;
            vr_q   <= 1'b0;
            idx_q  <= TEETH_W'(1);
            stb_q  <= 1'b0;
            rev_q  <= 1'b0;
            top_s  <= bus.tooth_top;
            gmul_s <= bus.gap_mult;
            last_s <= bus.teeth_last;
            loaded <= 1'b1;
        end else begin
            stb_q <= 1'b0;
            rev_q <= 1'b0;
            if (!loaded) begin
                top_s  <= bus.tooth_top;
                gmul_s <= bus.gap_mult;
                last_s <= bus.teeth_last;
                loaded <= 1'b1;
            end
            if (tick) begin
                pcnt <= '0;
                // End-of-tooth outranks the half-way edge, so a one-tick tooth never goes high.
                if (at_end) begin
                    tckc  <= '0;
                    vr_q  <= 1'b0;
                    stb_q <= 1'b1;
                    if (at_last) begin
                        idx_q  <= '0;
                        rev_q  <= 1'b1;
                        top_s  <= bus.tooth_top;
                        gmul_s <= bus.gap_mult;
                        last_s <= bus.teeth_last;
                    end else begin
                        idx_q <= idx_q + TEETH_W'(1);
                    end
                end else begin
                    if (at_half) begin
                        vr_q <= 1'b1;
                    end
                    tckc <= tckc + CW'(1);
                end
            end else begin
                pcnt <= pcnt + PRE_W'(1);
            end
        end
    end

    assign bus.vr_out    = vr_q;
    assign bus.tooth_idx = idx_q;
    assign bus.tooth_stb = stb_q;
    assign bus.rev_stb   = rev_q;
    assign bus.tick_cnt  = tckc;
endmodule

// File: tb/tb_crank_wheel_gen.sv
// Bench for crank_wheel_gen: timing table, reference-model waveform streams,
// strobe alignment monitor and en/reset corner sequences.
module tb_crank_wheel_gen;
    logic clk;
    logic rst;

    crank_wheel_gen_if bus ();

    crank_wheel_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int pre;
        int top;
        int gmul;
        int last;
        int e_stb;
        int e_rise;
        int e_rev;
        int e_gap;
    } vec_t;

    vec_t vecs[5];

    int n_cmp  = 0;
    int n_fail = 0;
    logic [10:0] exp_q[$];

    int cfg_pre, cfg_top, cfg_gmul, cfg_last;
    bit mon_on = 1'b0;
    logic prev_vr = 1'b0;
    logic prev_stb = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic restart(input int p, input int t, input int g, input int l);
        @(negedge clk);
        bus.en = 1'b0;
        cfg_pre = p; cfg_top = t; cfg_gmul = g; cfg_last = l;
        bus.prescale   = 8'(p);
        bus.tooth_top  = 16'(t);
        bus.gap_mult   = 2'(g);
        bus.teeth_last = 8'(l);
        repeat (2) @(negedge clk);
        bus.en = 1'b1;
    endtask

    // Edge counts from enable to: first tooth_stb, first vr rise, first rev_stb, and gap tooth length.
    task automatic measure(output int t_stb, output int t_rise, output int t_rev, output int t_gap);
        logic pv;
        t_stb = 0; t_rise = 0; t_rev = 0; t_gap = 0; pv = 1'b0;
        for (int k = 1; k <= 16000 && t_gap == 0; k++) begin
            @(negedge clk);
            if (bus.tooth_stb && t_stb == 0) t_stb = k;
            if (bus.vr_out && !pv && t_rise == 0) t_rise = k;
            if (bus.tooth_stb && t_rev != 0 && k > t_rev) t_gap = k - t_rev;
            if (bus.rev_stb && t_rev == 0) t_rev = k;
            pv = bus.vr_out;
        end
    endtask

    // Reference model: each tooth expands into one record per clk, built from its length in ticks.
    task automatic push_tooth(input int idx, input int len, input int p, input int nidx, input bit wrap);
        int h, per, c;
        logic vr;
        h = (len - 1) >> 1;
        per = p + 1;
        for (int q = 1; q <= len * per; q++) begin
            c = q / per;
            if (q == len * per) begin
                exp_q.push_back({1'b0, 8'(nidx), 1'b1, wrap});
            end else begin
                vr = (c >= h + 1);
                exp_q.push_back({vr, 8'(idx), 1'b0, 1'b0});
            end
        end
    endtask

    task automatic run_stream(input int ncyc, input int chg_tooth, input int chg_top);
        int idx, nidx, len, g, m_top, m_gmul, m_last;
        bit wrap;
        logic [10:0] exp;
        logic [10:0] act;
        exp_q.delete();
        m_top = cfg_top; m_gmul = cfg_gmul; m_last = cfg_last;
        idx = 1;
        for (int k = 0; k < ncyc; k++) begin
            if (exp_q.size() == 0) begin
                if (idx == chg_tooth) begin
                    cfg_top = chg_top;
                    bus.tooth_top = 16'(chg_top);
                end
                if (idx == 0) begin
                    m_top = cfg_top; m_gmul = cfg_gmul; m_last = cfg_last;
                end
                g = (m_gmul == 0) ? 1 : m_gmul;
                len = (idx == 0) ? g * (m_top + 1) : m_top + 1;
                wrap = (idx == m_last);
                nidx = wrap ? 0 : (idx + 1) % 256;
                push_tooth(idx, len, cfg_pre, nidx, wrap);
                idx = nidx;
            end
            @(negedge clk);
            exp = exp_q.pop_front();
            act = {bus.vr_out, bus.tooth_idx, bus.tooth_stb, bus.rev_stb};
            check("stream{vr,idx,stb,rev}", int'(act), int'(exp));
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (bus.tooth_stb) begin
                n_cmp++;
                if (!(prev_vr && !bus.vr_out && !prev_stb)) begin
                    n_fail++;
                    $display("FAIL stb_align: vr %0b->%0b prev_stb %0b, required 1->0 and 0",
                             prev_vr, bus.vr_out, prev_stb);
                end
            end
            if (bus.rev_stb) begin
                n_cmp++;
                if (!(bus.tooth_stb && bus.tooth_idx == 8'd0)) begin
                    n_fail++;
                    $display("FAIL rev_align: stb %0b idx %0d, required 1 and 0",
                             bus.tooth_stb, bus.tooth_idx);
                end
            end
        end
        prev_vr  = bus.vr_out;
        prev_stb = bus.tooth_stb;
    end

    initial begin
        int t_stb, t_rise, t_rev, t_gap, k;
        bit hit;

        vecs[0] = '{pre: 3, top: 63, gmul: 3, last: 57, e_stb: 256, e_rise: 128, e_rev: 14592, e_gap: 768};
        vecs[1] = '{pre: 0, top: 9,  gmul: 2, last: 3,  e_stb: 10,  e_rise: 5,   e_rev: 30,    e_gap: 20};
        vecs[2] = '{pre: 1, top: 4,  gmul: 0, last: 2,  e_stb: 10,  e_rise: 6,   e_rev: 20,    e_gap: 10};
        vecs[3] = '{pre: 2, top: 0,  gmul: 1, last: 1,  e_stb: 3,   e_rise: 0,   e_rev: 3,     e_gap: 3};
        vecs[4] = '{pre: 0, top: 1,  gmul: 3, last: 5,  e_stb: 2,   e_rise: 1,   e_rev: 10,    e_gap: 6};

        rst = 1'b0;
        bus.en = 1'b0;
        bus.prescale = 8'd3;
        bus.tooth_top = 16'd63;
        bus.gap_mult = 2'd3;
        bus.teeth_last = 8'd57;
        #12;
        check("reset_vr", int'(bus.vr_out), 0);
        check("reset_idx", int'(bus.tooth_idx), 1);
        check("reset_stb", int'(bus.tooth_stb), 0);
        check("reset_rev", int'(bus.rev_stb), 0);
        check("reset_tckc", int'(bus.tick_cnt), 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            restart(vecs[i].pre, vecs[i].top, vecs[i].gmul, vecs[i].last);
            measure(t_stb, t_rise, t_rev, t_gap);
            check($sformatf("row%0d_first_stb", i), t_stb, vecs[i].e_stb);
            check($sformatf("row%0d_vr_rise", i), t_rise, vecs[i].e_rise);
            check($sformatf("row%0d_rev", i), t_rev, vecs[i].e_rev);
            check($sformatf("row%0d_gap", i), t_gap, vecs[i].e_gap);
        end

        // Nominal wheel with tooth_top shrinking mid-revolution; new geometry from the next gap tooth.
        restart(3, 63, 3, 57);
        mon_on = 1'b1;
        run_stream(16000, 20, 31);
        mon_on = 1'b0;

        for (int r = 0; r < 8; r++) begin
            restart($urandom_range(0, 2), $urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(1, 4));
            run_stream(250, $urandom_range(1, cfg_last), $urandom_range(0, 6));
        end

        // Dropping en mid-tooth returns to tooth 1, tick 0.
        restart(1, 63, 3, 57);
        hit = 1'b0;
        for (int n = 0; n < 5000 && !hit; n++) begin
            @(negedge clk);
            hit = (bus.tooth_idx == 8'd30 && bus.tick_cnt == 18'd10);
        end
        check("en_drop_reached", int'(hit), 1);
        bus.en = 1'b0;
        @(negedge clk);
        check("en_drop_idx", int'(bus.tooth_idx), 1);
        check("en_drop_vr", int'(bus.vr_out), 0);
        check("en_drop_tckc", int'(bus.tick_cnt), 0);
        bus.en = 1'b1;
        k = 0;
        for (int n = 1; n <= 1000 && k == 0; n++) begin
            @(negedge clk);
            if (bus.tooth_stb) k = n;
        end
        check("reenable_first_stb", k, 128);

        // Asynchronous reset between clock edges clears vr_out without waiting for clk.
        restart(1, 7, 1, 3);
        hit = 1'b0;
        for (int n = 0; n < 100 && !hit; n++) begin
            @(negedge clk);
            hit = bus.vr_out;
        end
        check("async_vr_high", int'(hit), 1);
        #2 rst = 1'b0;
        #1;
        check("async_vr", int'(bus.vr_out), 0);
        check("async_idx", int'(bus.tooth_idx), 1);
        @(negedge clk);
        rst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
